// File: rtl/nec_ir_decoder.sv
// nec_ir_decoder: NEC IR frame decoder that supplies the held command byte to the input multiplexer.
// Optional feature macro NEC_INVERSE_CHECK_EN: accept only frames whose inverse bytes match.
module nec_ir_decoder #(
    parameter int unsigned TICK_DIV      = 117,
    parameter int unsigned HOLD_TICKS    = 2000,
    parameter bit          IR_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ir_in,
    output logic [31:0] ir_data,
    output logic        frame_valid,
    output logic        repeat_valid,
    output logic [7:0]  ir_mux,
    output logic        busy
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HW = $clog2(HOLD_TICKS + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS);

    localparam logic [7:0] LEAD_MIN = 8'd128;
    localparam logic [7:0] LEAD_MAX = 8'd192;
    localparam logic [7:0] DATA_MIN = 8'd64;
    localparam logic [7:0] DATA_MAX = 8'd96;
    localparam logic [7:0] REP_MIN  = 8'd32;
    localparam logic [7:0] REP_MAX  = 8'd48;
    localparam logic [7:0] BIT_MIN  = 8'd6;
    localparam logic [7:0] BIT_MAX  = 8'd14;
    localparam logic [7:0] ONE_MIN  = 8'd22;
    localparam logic [7:0] ONE_MAX  = 8'd38;
    localparam logic [7:0] WIDTH_SAT = 8'hFF;

    typedef enum logic [2:0] {
        StIdle,
        StLeadMark,
        StLeadSpace,
        StBitMark,
        StBitSpace,
        StTrailMark,
        StRepMark
    } state_e;

    state_e          state_q;
    logic [1:0]      sync_q;
    logic            mark_q;
    logic [PW-1:0]   presc_q;
    logic [7:0]      width_q;
    logic [31:0]     shift_q;
    logic [4:0]      bit_idx_q;
    logic [HW-1:0]   hold_q;

    logic mark, mark_rise, mark_fall, tick;
    logic lead_ok, data_ok, rep_ok, bit_ok, one_ok, inverse_ok;

    function automatic logic in_win(input logic [7:0] w, input logic [7:0] lo,
                                    input logic [7:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

    // Synchronizer resets to the idle line level so release from reset is not seen as an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {2{IR_ACTIVE_LOW}};
            mark_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], ir_in};
            mark_q <= mark;
        end
    end

    assign mark      = sync_q[1] ^ IR_ACTIVE_LOW;
    assign mark_rise = mark & ~mark_q;
    assign mark_fall = ~mark & mark_q;
    assign tick      = (presc_q == PRESC_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            width_q <= '0;
        end else begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
            if (mark_rise || mark_fall) begin
                width_q <= '0;
            end else if (tick && width_q != WIDTH_SAT) begin
                width_q <= width_q + 8'd1;
            end
        end
    end

    assign lead_ok = in_win(width_q, LEAD_MIN, LEAD_MAX);
    assign data_ok = in_win(width_q, DATA_MIN, DATA_MAX);
    assign rep_ok  = in_win(width_q, REP_MIN, REP_MAX);
    assign bit_ok  = in_win(width_q, BIT_MIN, BIT_MAX);
    assign one_ok  = in_win(width_q, ONE_MIN, ONE_MAX);

`ifdef NEC_INVERSE_CHECK_EN
    assign inverse_ok = (shift_q[15:8] == ~shift_q[7:0]) && (shift_q[31:24] == ~shift_q[23:16]);
`else
    assign inverse_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            hold_q       <= '0;
            ir_data      <= '0;
            frame_valid  <= 1'b0;
            repeat_valid <= 1'b0;
        end else begin
            frame_valid  <= 1'b0;
            repeat_valid <= 1'b0;
            // Reloads below override this decrement when both happen on one clk.
            if (tick && hold_q != '0) begin
                hold_q <= hold_q - HW'(1);
            end
            if (state_q != StIdle && width_q == WIDTH_SAT) begin
                state_q <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (mark_rise) state_q <= StLeadMark;
                    end
                    StLeadMark: begin
                        if (mark_fall) state_q <= lead_ok ? StLeadSpace : StIdle;
                    end
                    StLeadSpace: begin
                        if (mark_rise) begin
                            if (data_ok) begin
                                state_q   <= StBitMark;
                                bit_idx_q <= '0;
                            end else if (rep_ok) begin
                                state_q <= StRepMark;
                            end else begin
                                state_q <= StIdle;
                            end
                        end
                    end
                    StBitMark: begin
                        if (mark_fall) state_q <= bit_ok ? StBitSpace : StIdle;
                    end
                    StBitSpace: begin
                        if (mark_rise) begin
                            if (bit_ok || one_ok) begin
                                shift_q <= {one_ok, shift_q[31:1]};
                                if (bit_idx_q == 5'd31) begin
                                    state_q <= StTrailMark;
                                end else begin
                                    bit_idx_q <= bit_idx_q + 5'd1;
                                    state_q   <= StBitMark;
                                end
                            end else begin
                                state_q <= StIdle;
                            end
                        end
                    end
                    StTrailMark: begin
                        if (mark_fall) begin
                            if (bit_ok && inverse_ok) begin
                                ir_data     <= shift_q;
                                frame_valid <= 1'b1;
                                hold_q      <= HOLD_LOAD;
                            end
                            state_q <= StIdle;
                        end
                    end
                    StRepMark: begin
                        if (mark_fall) begin
                            if (bit_ok && hold_q != '0) begin
                                repeat_valid <= 1'b1;
                                hold_q       <= HOLD_LOAD;
                            end
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign ir_mux = (hold_q != '0) ? ir_data[23:16] : 8'h00;
    assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_nec_ir_decoder.sv
// tb_nec_ir_decoder: randomized NEC frames/repeats checked against a timing-rule reference model.
// Prescaler is shortened so the hold window fits a short run; NEC widths stay in ticks.
module tb_nec_ir_decoder;

    localparam int unsigned TDIV = 2;
    localparam int unsigned HOLD = 2000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ir_in = 1'b1;
    logic [31:0] ir_data;
    logic        frame_valid;
    logic        repeat_valid;
    logic [7:0]  ir_mux;
    logic        busy;

    nec_ir_decoder #(
        .TICK_DIV      (TDIV),
        .HOLD_TICKS    (HOLD),
        .IR_ACTIVE_LOW (1'b1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ir_in        (ir_in),
        .ir_data      (ir_data),
        .frame_valid  (frame_valid),
        .repeat_valid (repeat_valid),
        .ir_mux       (ir_mux),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    int     fv_cnt = 0;
    int     rv_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (frame_valid)  fv_cnt <= fv_cnt + 1;
        if (repeat_valid) rv_cnt <= rv_cnt + 1;
    end

    // Reference model: last accepted frame and the cycle of the last accepted frame/repeat.
    logic [31:0] m_data = '0;
    bit          m_hold = 1'b0;
    longint      m_last = 0;
    longint      trail_cyc = 0;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int jit(input int n, input int j);
        return n - j + int'($urandom_range(2 * j, 0));
    endfunction

    function automatic bit hold_active(input longint at);
        return m_hold && ((at - m_last) < longint'(HOLD * TDIV));
    endfunction

    task automatic drive(input bit m, input int ticks);
        ir_in = ~m;
        repeat (ticks * TDIV) @(posedge clk);
        #1;
    endtask

    task automatic check_mux(input string tag);
        longint el;
        el = cyc - m_last;
        if (!m_hold || el > longint'((HOLD + 10) * TDIV))
            check_eq({tag, "_mux"}, {24'h0, ir_mux}, 32'h0);
        else if (el < longint'((HOLD - 10) * TDIV))
            check_eq({tag, "_mux"}, {24'h0, ir_mux}, {24'h0, m_data[23:16]});
    endtask

    task automatic expect_txn(input string tag, input int fv0, input int rv0,
                              input int exp_fv, input int exp_rv);
        check_eq({tag, "_fv"}, 32'(fv_cnt - fv0), 32'(exp_fv));
        check_eq({tag, "_rv"}, 32'(rv_cnt - rv0), 32'(exp_rv));
        check_eq({tag, "_data"}, ir_data, m_data);
        check_eq({tag, "_busy"}, {31'h0, busy}, 32'h0);
        check_mux(tag);
    endtask

    task automatic send_frame(input logic [31:0] word, input int lead, input int bad_bit,
                              input int bad_space, input int abort_bit);
        drive(1'b1, lead);
        drive(1'b0, jit(80, 4));
        for (int i = 0; i < 32; i++) begin
            if (i == abort_bit) begin
                reset_n = 1'b0;
                drive(1'b0, 20);
                reset_n = 1'b1;
                return;
            end
            drive(1'b1, jit(10, 2));
            if (i == bad_bit) drive(1'b0, bad_space);
            else drive(1'b0, word[i] ? jit(30, 3) : jit(10, 2));
        end
        drive(1'b1, jit(10, 2));
        trail_cyc = cyc;
        drive(1'b0, 40);
    endtask

    task automatic frame_txn(input string tag, input logic [31:0] word, input int lead,
                             input int bad_bit, input int bad_space);
        int fv0, rv0;
        bit ok;
        fv0 = fv_cnt;
        rv0 = rv_cnt;
        send_frame(word, lead, bad_bit, bad_space, -1);
        ok = (lead >= 128) && (lead <= 192) && (bad_bit < 0);
`ifdef NEC_INVERSE_CHECK_EN
        ok = ok && (word[15:8] == ~word[7:0]) && (word[31:24] == ~word[23:16]);
`endif
        if (ok) begin
            m_data = word;
            m_hold = 1'b1;
            m_last = trail_cyc;
        end
        expect_txn(tag, fv0, rv0, ok ? 1 : 0, 0);
    endtask

    task automatic repeat_txn(input string tag);
        int fv0, rv0;
        bit ok;
        fv0 = fv_cnt;
        rv0 = rv_cnt;
        drive(1'b1, jit(160, 8));
        drive(1'b0, jit(40, 3));
        drive(1'b1, jit(10, 2));
        trail_cyc = cyc;
        drive(1'b0, 40);
        ok = hold_active(trail_cyc);
        if (ok) m_last = trail_cyc;
        expect_txn(tag, fv0, rv0, 0, ok ? 1 : 0);
    endtask

    function automatic logic [31:0] nec_word(input logic [7:0] addr, input logic [7:0] cmd);
        return {~cmd, cmd, ~addr, addr};
    endfunction

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int fv0, rv0;

        // Line toggling while held in reset.
        for (int i = 0; i < 40; i++) begin
            ir_in = 1'($urandom);
            repeat (5) @(posedge clk);
            #1;
        end
        check_eq("rst_data", ir_data, 32'h0);
        check_eq("rst_fv", {31'h0, frame_valid}, 32'h0);
        check_eq("rst_rv", {31'h0, repeat_valid}, 32'h0);
        check_eq("rst_mux", {24'h0, ir_mux}, 32'h0);
        check_eq("rst_busy", {31'h0, busy}, 32'h0);
        ir_in = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive(1'b0, 20);

        frame_txn("frm45", 32'hBA45FF00, 160, -1, 0);
        check_eq("frm45_word", ir_data, 32'hBA45FF00);
        check_eq("frm45_mux", {24'h0, ir_mux}, 32'h45);

        // Held key: repeats keep the hold window alive.
        for (int r = 0; r < 5; r++) begin
            drive(1'b0, 1660);
            repeat_txn($sformatf("rep%0d", r));
            check_eq($sformatf("rep%0d_mux45", r), {24'h0, ir_mux}, 32'h45);
        end

        while (cyc < m_last + longint'((HOLD - 50) * TDIV)) @(posedge clk);
        #1;
        check_eq("hold_before", {24'h0, ir_mux}, 32'h45);
        while (cyc < m_last + longint'((HOLD + 50) * TDIV)) @(posedge clk);
        #1;
        check_eq("hold_after", {24'h0, ir_mux}, 32'h0);

        repeat_txn("orphan");
        check_eq("orphan_mux", {24'h0, ir_mux}, 32'h0);

        for (int k = 0; k < 4; k++) begin
            frame_txn($sformatf("rnd%0d", k), nec_word(8'($urandom), 8'($urandom)),
                      int'($urandom_range(170, 150)), -1, 0);
        end

        frame_txn("bad12", nec_word(8'h12, 8'h34), 160, 12, 19);
        for (int k = 0; k < 2; k++) begin
            frame_txn($sformatf("badrnd%0d", k), nec_word(8'($urandom), 8'($urandom)), 160,
                      int'($urandom_range(31, 0)), int'($urandom_range(21, 16)));
        end

        frame_txn("lead5ms", nec_word(8'h01, 8'h02), 89, -1, 0);

        // Stuck mark saturates the width counter and aborts.
        fv0 = fv_cnt;
        rv0 = rv_cnt;
        drive(1'b1, 356);
        check_eq("stuck_busy", {31'h0, busy}, 32'h0);
        drive(1'b0, 40);
        expect_txn("stuck", fv0, rv0, 0, 0);

        frame_txn("noinv", 32'h0045FF00, 160, -1, 0);

        // Reset at bit 20 discards everything.
        fv0 = fv_cnt;
        rv0 = rv_cnt;
        send_frame(nec_word(8'h5A, 8'hC3), 160, -1, 0, 20);
        m_data = '0;
        m_hold = 1'b0;
        drive(1'b0, 20);
        expect_txn("midrst", fv0, rv0, 0, 0);

        frame_txn("postrst", nec_word(8'($urandom), 8'($urandom)), 160, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
